// File: rtl/gcd_sequencer.sv
// gcd_sequencer: request FIFO plus control FSM that feeds operand pairs to an
// external multi-cycle GCD core and returns {a, b, gcd, err} on a result
// handshake. A pair with a zero operand bypasses the core: gcd(0,x) = x.
//
// Build option: define GCD_SEQ_TIMEOUT_EN to add a WAIT-state watchdog. When
// the core has not reported done after TIMEOUT_CYCLES WAIT cycles, the job is
// retired with res_gcd = 0 and res_err = 1. Without the macro there is no
// counter and res_err is tied low.
module gcd_sequencer #(
  parameter int WIDTH          = 8,
  parameter int DEPTH          = 4,
  parameter int TIMEOUT_CYCLES = 600
) (
  input  logic             clk,
  input  logic             reset,
  // operand request handshake
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  // GCD core interface
  output logic [WIDTH-1:0] core_a,
  output logic [WIDTH-1:0] core_b,
  output logic             core_load,
  output logic             core_en,
  input  logic [WIDTH-1:0] core_ans,
  input  logic             core_done,
  // result handshake
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_a,
  output logic [WIDTH-1:0] res_b,
  output logic [WIDTH-1:0] res_gcd,
  output logic             res_err,
  output logic             busy
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  // Reject parameter values the FIFO and watchdog cannot honour.
  generate
    if (DEPTH < 1 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("gcd_sequencer: DEPTH must be a power of two");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
      $error("gcd_sequencer: TIMEOUT_CYCLES must be at least 1");
    end
  endgenerate

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_WAIT = 2'd2,
    ST_OUT  = 2'd3
  } state_t;

  // ---------------------------------------------------------------------------
  // Request FIFO
  // ---------------------------------------------------------------------------
  logic [2*WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0]   r_wr_ptr;
  logic [PTR_W-1:0]   r_rd_ptr;
  logic [CNT_W-1:0]   r_count;

  logic               w_push;
  logic               w_pop;
  logic               w_empty;
  logic               w_full;
  logic [2*WIDTH-1:0] w_head;
  logic [WIDTH-1:0]   w_head_a;
  logic [WIDTH-1:0]   w_head_b;
  logic               w_head_zero;
  logic               w_timeout;

  state_t             r_state;
  logic [WIDTH-1:0]   r_core_a;
  logic [WIDTH-1:0]   r_core_b;
  logic               r_core_load;
  logic               r_core_en;
  logic               r_res_valid;
  logic [WIDTH-1:0]   r_res_a;
  logic [WIDTH-1:0]   r_res_b;
  logic [WIDTH-1:0]   r_res_gcd;

  // Full/empty come from the registered count only, so a pop in the same
  // cycle never re-opens in_ready; the freed slot shows up one cycle later.
  assign w_full   = (r_count == CNT_W'(DEPTH));
  assign w_empty  = (r_count == '0);
  assign in_ready = !w_full;
  assign w_push   = in_valid && !w_full;

  assign w_head      = r_mem[r_rd_ptr];
  assign w_head_a    = w_head[2*WIDTH-1:WIDTH];
  assign w_head_b    = w_head[WIDTH-1:0];
  assign w_head_zero = (w_head_a == '0) || (w_head_b == '0);

  // The head leaves the FIFO when its result is decided: immediately on the
  // bypass path, or when the core finishes (or the watchdog fires) in WAIT.
  assign w_pop = ((r_state == ST_IDLE) && !w_empty && w_head_zero) ||
                 ((r_state == ST_WAIT) && (core_done || w_timeout));

  // FIFO storage: write-only port, no reset needed for the payload.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= {in_a, in_b};
    end
  end

  // FIFO pointers and occupancy; pointers wrap explicitly at DEPTH-1.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= (r_rd_ptr == PTR_W'(DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Optional WAIT watchdog
  // ---------------------------------------------------------------------------
`ifdef GCD_SEQ_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [TO_W-1:0] r_wait_cnt;
  logic            r_res_err;

  // Fires on the TIMEOUT_CYCLES-th consecutive WAIT cycle.
  assign w_timeout = (r_state == ST_WAIT) &&
                     (r_wait_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // Counts completed WAIT cycles; cleared in every other state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_WAIT) begin
      r_wait_cnt <= r_wait_cnt + TO_W'(1);
    end else begin
      r_wait_cnt <= '0;
    end
  end

  // Error flag set only by a watchdog retirement, cleared by any other result.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_res_err <= 1'b0;
    end else if (r_state == ST_IDLE && !w_empty && w_head_zero) begin
      r_res_err <= 1'b0;
    end else if (r_state == ST_WAIT) begin
      if (core_done) begin
        r_res_err <= 1'b0;
      end else if (w_timeout) begin
        r_res_err <= 1'b1;
      end
    end
  end

  assign res_err = r_res_err;
`else
  assign w_timeout = 1'b0;
  assign res_err   = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Control FSM with registered core and result outputs
  // ---------------------------------------------------------------------------
  // One job at a time: IDLE picks the head, LOAD pulses core_load, WAIT runs
  // the core, OUT holds the result until the consumer takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_core_a    <= '0;
      r_core_b    <= '0;
      r_core_load <= 1'b0;
      r_core_en   <= 1'b0;
      r_res_valid <= 1'b0;
      r_res_a     <= '0;
      r_res_b     <= '0;
      r_res_gcd   <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (!w_empty) begin
            if (w_head_zero) begin
              // gcd(0,x) = x and gcd(0,0) = 0, so OR-ing gives the answer.
              r_res_a     <= w_head_a;
              r_res_b     <= w_head_b;
              r_res_gcd   <= w_head_a | w_head_b;
              r_res_valid <= 1'b1;
              r_state     <= ST_OUT;
            end else begin
              r_core_a    <= w_head_a;
              r_core_b    <= w_head_b;
              r_core_load <= 1'b1;
              r_state     <= ST_LOAD;
            end
          end
        end
        ST_LOAD: begin
          r_core_load <= 1'b0;
          r_core_en   <= 1'b1;
          r_state     <= ST_WAIT;
        end
        ST_WAIT: begin
          // core_a/core_b are left untouched so they stay stable for the core.
          if (core_done) begin
            r_core_en   <= 1'b0;
            r_res_a     <= r_core_a;
            r_res_b     <= r_core_b;
            r_res_gcd   <= core_ans;
            r_res_valid <= 1'b1;
            r_state     <= ST_OUT;
          end else if (w_timeout) begin
            r_core_en   <= 1'b0;
            r_res_a     <= r_core_a;
            r_res_b     <= r_core_b;
            r_res_gcd   <= '0;
            r_res_valid <= 1'b1;
            r_state     <= ST_OUT;
          end
        end
        ST_OUT: begin
          if (res_ready) begin
            r_res_valid <= 1'b0;
            r_state     <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign core_a    = r_core_a;
  assign core_b    = r_core_b;
  assign core_load = r_core_load;
  assign core_en   = r_core_en;
  assign res_valid = r_res_valid;
  assign res_a     = r_res_a;
  assign res_b     = r_res_b;
  assign res_gcd   = r_res_gcd;
  assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_gcd_sequencer.sv
// Bench for gcd_sequencer: a behavioural GCD core answers core_load/core_en,
// expected results are queued when requests are accepted and checked when the
// result handshake completes. Watchdog scenario runs when GCD_SEQ_TIMEOUT_EN
// is defined.
module tb_gcd_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_a;
  logic [7:0] in_b;
  logic [7:0] core_a;
  logic [7:0] core_b;
  logic       core_load;
  logic       core_en;
  logic [7:0] core_ans;
  logic       core_done;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] res_a;
  logic [7:0] res_b;
  logic [7:0] res_gcd;
  logic       res_err;
  logic       busy;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] g;
    logic       e;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  int   load_cnt = 0;

  // core model controls
  int   core_delay = 0;
  bit   core_hang  = 1'b0;
  logic stray = 1'b0;
  logic m_done;
  logic [7:0] m_ans;
  int   m_cnt;

  always #5 clk = ~clk;

  gcd_sequencer #(.WIDTH(8), .DEPTH(4), .TIMEOUT_CYCLES(600)) dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .core_a    (core_a),
    .core_b    (core_b),
    .core_load (core_load),
    .core_en   (core_en),
    .core_ans  (core_ans),
    .core_done (core_done),
    .res_valid (res_valid),
    .res_ready (res_ready),
    .res_a     (res_a),
    .res_b     (res_b),
    .res_gcd   (res_gcd),
    .res_err   (res_err),
    .busy      (busy)
  );

  assign core_done = m_done | stray;
  assign core_ans  = m_ans;

  function automatic logic [7:0] gcd_ref(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] x;
    logic [7:0] y;
    logic [7:0] t;
    x = a;
    y = b;
    while (y != 0) begin
      t = y;
      y = x % y;
      x = t;
    end
    return x;
  endfunction

  // Behavioural core: answers core_delay cycles after core_load (0 = first WAIT cycle).
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_done <= 1'b0;
      m_ans  <= 8'd0;
      m_cnt  <= 0;
    end else if (core_load) begin
      m_ans <= gcd_ref(core_a, core_b);
      if (core_hang) begin
        m_done <= 1'b0;
        m_cnt  <= 0;
      end else if (core_delay == 0) begin
        m_done <= 1'b1;
        m_cnt  <= 0;
      end else begin
        m_done <= 1'b0;
        m_cnt  <= core_delay;
      end
    end else if (m_done) begin
      m_done <= 1'b0;
    end else if (core_en && m_cnt != 0 && !core_hang) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) m_done <= 1'b1;
    end
  end

  // core_load pulse counter
  initial begin
    forever begin
      @(negedge clk);
      if (core_load === 1'b1) load_cnt++;
    end
  end

  // Result monitor / scoreboard
  initial begin
    exp_t ex;
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && res_valid === 1'b1 && res_ready === 1'b1) begin
        total++;
        if (sb.size() == 0) begin
          bad++;
          $display("FAIL unexpected_result: got a=%0d b=%0d gcd=%0d err=%0b, required no result",
                   res_a, res_b, res_gcd, res_err);
        end else begin
          ex = sb.pop_front();
          if ({res_a, res_b, res_gcd, res_err} !== {ex.a, ex.b, ex.g, ex.e}) begin
            bad++;
            $display("FAIL result: got a=%0d b=%0d gcd=%0d err=%0b, required a=%0d b=%0d gcd=%0d err=%0b",
                     res_a, res_b, res_gcd, res_err, ex.a, ex.b, ex.g, ex.e);
          end else begin
            $display("result a=%0d b=%0d gcd=%0d err=%0b ok", res_a, res_b, res_gcd, res_err);
          end
        end
      end
    end
  end

  // Global safety net
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "time limit");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Offer a request until accepted; optionally queue its expected result.
  task automatic push_req(input logic [7:0] a, input logic [7:0] b, input bit track,
                          input logic [7:0] g, input logic e);
    bit ok;
    exp_t ex;
    ok = 1'b0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    for (int k = 0; k < 2000; k++) begin
      @(negedge clk);
      if (in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      bad++;
      $display("FAIL push_accept: (%0d,%0d) not accepted, required acceptance", a, b);
    end else if (track) begin
      ex.a = a; ex.b = b; ex.g = g; ex.e = e;
      sb.push_back(ex);
    end
    $display("push a=%0d b=%0d accepted=%0b", a, b, ok);
    tick();
    in_valid = 1'b0;
  endtask

  // Let the consumer take everything queued, bounded in cycles.
  task automatic drain(input string nm);
    bit ok;
    ok = 1'b0;
    res_ready = 1'b1;
    for (int k = 0; k < 3000; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && busy === 1'b0) begin
        ok = 1'b1;
        break;
      end
    end
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s_drain: pending=%0d busy=%0b, required pending=0 busy=0", nm, sb.size(), busy);
    end
    tick();
    res_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    in_valid = 1'b0;
    in_a = 8'd0;
    in_b = 8'd0;
    res_ready = 1'b0;
    repeat (3) @(negedge clk);
    total++;
    if ({core_load, core_en, res_valid, res_err, busy} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags: got load/en/valid/err/busy=%b, required 00000",
               {core_load, core_en, res_valid, res_err, busy});
    end
    total++;
    if ({core_a, core_b, res_a, res_b, res_gcd} !== 40'd0) begin
      bad++;
      $display("FAIL reset_data: got core_a=%0d core_b=%0d res_a=%0d res_b=%0d res_gcd=%0d, required all 0",
               core_a, core_b, res_a, res_b, res_gcd);
    end
    tick();
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1) begin
      bad++;
      $display("FAIL reset_in_ready: got %b, required 1", in_ready);
    end
    tick();
  endtask

  task automatic test_core();
    int lat;
    int l0;
    logic [7:0] ga;
    logic [7:0] gb;
    core_delay = 0;
    res_ready = 1'b0;
    l0 = load_cnt;
    lat = 0;
    ga = 8'd0;
    gb = 8'd0;
    push_req(8'd200, 8'd68, 1'b1, 8'd4, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (core_load === 1'b1) begin
        ga = core_a;
        gb = core_b;
      end
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 4) begin
      bad++;
      $display("FAIL core_latency: got %0d, required 4", lat);
    end
    total++;
    if (load_cnt - l0 != 1) begin
      bad++;
      $display("FAIL core_load_pulses: got %0d, required 1", load_cnt - l0);
    end
    total++;
    if (ga !== 8'd200 || gb !== 8'd68) begin
      bad++;
      $display("FAIL core_operands: got (%0d,%0d), required (200,68)", ga, gb);
    end
    repeat (3) tick();
    @(negedge clk);
    total++;
    if ({res_valid, res_gcd, core_en, busy} !== {1'b1, 8'd4, 1'b0, 1'b1}) begin
      bad++;
      $display("FAIL out_hold: got valid=%b gcd=%0d en=%b busy=%b, required valid=1 gcd=4 en=0 busy=1",
               res_valid, res_gcd, core_en, busy);
    end
    tick();
    drain("core");

    core_delay = 3;
    push_req(8'd48, 8'd18, 1'b1, 8'd6, 1'b0);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (core_en === 1'b1) break;
    end
    repeat (2) @(negedge clk);
    total++;
    if ({core_en, core_a, core_b, res_valid} !== {1'b1, 8'd48, 8'd18, 1'b0}) begin
      bad++;
      $display("FAIL wait_hold: got en=%b a=%0d b=%0d valid=%b, required en=1 a=48 b=18 valid=0",
               core_en, core_a, core_b, res_valid);
    end
    tick();
    drain("core2");
    core_delay = 0;
  endtask

  task automatic test_bypass();
    int lat;
    int l0;
    res_ready = 1'b0;
    l0 = load_cnt;
    stray = 1'b1;
    tick();
    stray = 1'b0;
    @(negedge clk);
    total++;
    if (busy !== 1'b0 || res_valid !== 1'b0) begin
      bad++;
      $display("FAIL stray_done: got busy=%b valid=%b, required 0 0", busy, res_valid);
    end
    tick();
    lat = 0;
    push_req(8'd0, 8'd45, 1'b1, 8'd45, 1'b0);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 2) begin
      bad++;
      $display("FAIL bypass_latency: got %0d, required 2", lat);
    end
    tick();
    drain("bypass1");
    push_req(8'd0, 8'd0, 1'b1, 8'd0, 1'b0);
    drain("bypass2");
    push_req(8'd7, 8'd0, 1'b1, 8'd7, 1'b0);
    drain("bypass3");
    total++;
    if (load_cnt != l0) begin
      bad++;
      $display("FAIL bypass_no_load: got %0d core_load pulses, required 0", load_cnt - l0);
    end
  endtask

  task automatic test_back_to_back();
    res_ready = 1'b0;
    core_delay = 5;
    push_req(8'd120, 8'd40, 1'b1, 8'd40, 1'b0);
    push_req(8'd21, 8'd24, 1'b1, 8'd3, 1'b0);
    push_req(8'd55, 8'd66, 1'b1, 8'd11, 1'b0);
    push_req(8'd78, 8'd169, 1'b1, 8'd13, 1'b0);
    @(negedge clk);
    total++;
    if (in_ready !== 1'b0) begin
      bad++;
      $display("FAIL full_in_ready: got %b after 4 acceptances, required 0", in_ready);
    end
    tick();
    push_req(8'd36, 8'd48, 1'b1, 8'd12, 1'b0);
    drain("full");
    core_delay = 0;
  endtask

`ifdef GCD_SEQ_TIMEOUT_EN
  task automatic test_timeout();
    int lat;
    res_ready = 1'b0;
    core_hang = 1'b1;
    lat = 0;
    push_req(8'd12, 8'd18, 1'b1, 8'd0, 1'b1);
    for (int k = 1; k <= 800; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1) begin
        lat = k;
        break;
      end
    end
    total++;
    if (lat != 603) begin
      bad++;
      $display("FAIL timeout_latency: got %0d, required 603 (600 WAIT cycles)", lat);
    end
    total++;
    if (core_en !== 1'b0 || res_err !== 1'b1) begin
      bad++;
      $display("FAIL timeout_flags: got en=%b err=%b, required en=0 err=1", core_en, res_err);
    end
    tick();
    core_hang = 1'b0;
    drain("timeout");
    push_req(8'd12, 8'd18, 1'b1, 8'd6, 1'b0);
    drain("after_timeout");
  endtask
`endif

  task automatic test_reset_mid();
    bit seen;
    res_ready = 1'b1;
    core_hang = 1'b1;
    push_req(8'd255, 8'd2, 1'b0, 8'd0, 1'b0);
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (core_en === 1'b1) break;
    end
    tick();
    push_req(8'd9, 8'd6, 1'b0, 8'd0, 1'b0);
    push_req(8'd10, 8'd4, 1'b0, 8'd0, 1'b0);
    repeat (7) tick();
    total++;
    if (core_en !== 1'b1) begin
      bad++;
      $display("FAIL mid_wait: got core_en=%b before reset, required 1", core_en);
    end
    reset = 1'b0;
    #1;
    total++;
    if ({core_load, core_en, res_valid, res_err, busy, core_a, core_b, res_a, res_b, res_gcd} !== 45'd0) begin
      bad++;
      $display("FAIL async_reset: got en=%b busy=%b core_a=%0d core_b=%0d, required all 0",
               core_en, busy, core_a, core_b);
    end
    tick();
    tick();
    reset = 1'b1;
    core_hang = 1'b0;
    @(negedge clk);
    total++;
    if (in_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL post_reset: got in_ready=%b busy=%b, required 1 0", in_ready, busy);
    end
    seen = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (res_valid === 1'b1 || busy === 1'b1) seen = 1'b1;
    end
    total++;
    if (seen) begin
      bad++;
      $display("FAIL stale_job: got activity after reset, required none");
    end
    tick();
    push_req(8'd9, 8'd6, 1'b1, 8'd3, 1'b0);
    drain("after_reset");
  endtask

  initial begin
    test_reset();
    test_core();
    test_bypass();
    test_back_to_back();
`ifdef GCD_SEQ_TIMEOUT_EN
    test_timeout();
`endif
    test_reset_mid();
    total++;
    if (sb.size() != 0) begin
      bad++;
      $display("FAIL leftover: got %0d queued results, required 0", sb.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
